// File: rtl/adc08xx_pkg.sv
// Shared types and derived timing for the ADC0808/0809 scan controller.
// All constants are in system-clock cycles unless the name says otherwise.
package adc08xx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LATCH,
      WAIT_FALL,
      WAIT_RISE,
      READ,
      NEXT,
      FRAME_WAIT
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] ch;
   } ch_sel_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Half period of the ADC clock; clk_fre in MHz, adc_clk_fre in kHz.
   function automatic int calc_half(input int clk_fre, input int adc_clk_fre);
      return clk_fre * 500 / adc_clk_fre;
   endfunction

   // ALE/START width of about 200 ns, never shorter than one cycle.
   function automatic int calc_st_cyc(input int clk_fre);
      return max2(1, clk_fre / 5);
   endfunction

   // OE is held for two full ADC clock periods.
   function automatic int calc_oe_cyc(input int half);
      return 2 * 2 * half;
   endfunction

   function automatic int calc_frame_cyc(input int clk_fre, input int frame_fre);
      return 1_000_000 * clk_fre / frame_fre;
   endfunction

   function automatic int calc_eoc_fall_to(input int clk_fre);
      return clk_fre * 10;
   endfunction

   function automatic int calc_conv_to(input int clk_fre, input int conv_to_us);
      return clk_fre * conv_to_us;
   endfunction

   // Lowest enabled channel strictly above cur; pass cur = -1 for the first one.
   function automatic ch_sel_t next_enabled_ch(input logic [7:0] mask, input int cur);
      ch_sel_t sel;
      sel = '0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (i > cur)) begin
            sel.found = 1'b1;
            sel.ch    = 3'(i);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/adc08xx_scan_if.sv
// Board-side pin bundle of an ADC0808/0809-class converter.
// master = scan controller, slave = converter (or its model).
interface adc08xx_scan_if #(
   parameter int DATA_W = 8
);
   logic [2:0]        adc_addr;
   logic              adc_ale;
   logic              adc_st;
   logic              adc_oe;
   logic              adc_clk;
   logic              adc_eoc;
   logic [DATA_W-1:0] adc_db;

   modport master (
      output adc_addr, adc_ale, adc_st, adc_oe, adc_clk,
      input  adc_eoc, adc_db
   );

   modport slave (
      input  adc_addr, adc_ale, adc_st, adc_oe, adc_clk,
      output adc_eoc, adc_db
   );
endinterface

// File: rtl/adc_clk_div.sv
// Free-running 50% duty clock divider: output toggles every HALF input cycles.
// Generic enough to clock other ADC/DAC front ends.
module adc_clk_div #(
   parameter int HALF = 39
) (
   input  logic clk,
   input  logic rst,
   output logic adc_clk
);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         adc_clk <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt     <= '0;
         adc_clk <= ~adc_clk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc08xx_scan.sv
// Multi-channel scan controller for ADC0808/0809: drives ALE/START/OE, waits on EOC,
// streams samples and keeps the last good value of every channel.
module adc08xx_scan
   import adc08xx_pkg::*;
#(
   parameter int CLK_FRE     = 50,
   parameter int ADC_CLK_FRE = 640,
   parameter int FRAME_FRE   = 1000,
   parameter int CH_NUM      = 8,
   parameter int DATA_W      = 8,
   parameter int CONV_TO_US  = 200
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           cont,
   input  logic [CH_NUM-1:0]              ch_mask,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           smp_valid,
   output logic [2:0]                     smp_ch,
   output logic [DATA_W-1:0]              smp_data,
   output logic [CH_NUM-1:0][DATA_W-1:0]  ch_data,
   output logic                           err_timeout,
   output logic [2:0]                     err_ch,
   adc08xx_scan_if.master                 adc
);

   localparam int HALF        = calc_half(CLK_FRE, ADC_CLK_FRE);
   localparam int ST_CYC      = calc_st_cyc(CLK_FRE);
   localparam int OE_CYC      = calc_oe_cyc(HALF);
   localparam int EOC_FALL_TO = calc_eoc_fall_to(CLK_FRE);
   localparam int CONV_TO     = calc_conv_to(CLK_FRE, CONV_TO_US);
   localparam int FRAME_CYC   = calc_frame_cyc(CLK_FRE, FRAME_FRE);

   localparam int TMR_MAX = max2(max2(ST_CYC, OE_CYC), max2(EOC_FALL_TO, CONV_TO));
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FCNT_W  = $clog2(FRAME_CYC + 1);

   localparam logic [TMR_W-1:0]  ST_LAST    = TMR_W'(ST_CYC - 1);
   localparam logic [TMR_W-1:0]  OE_LAST    = TMR_W'(OE_CYC - 1);
   localparam logic [TMR_W-1:0]  FALL_LAST  = TMR_W'(EOC_FALL_TO - 1);
   localparam logic [TMR_W-1:0]  CONV_LAST  = TMR_W'(CONV_TO - 1);
   localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_CYC - 1);

   state_t              state;
   logic [TMR_W-1:0]    tmr;
   logic [FCNT_W-1:0]   frame_cnt;
   logic [CH_NUM-1:0]   mask_q;
   logic                cont_q;
   logic [2:0]          addr_q;
   logic                ale_q;
   logic                st_q;
   logic                oe_q;
   logic                adc_clk_int;
   logic [1:0]          eoc_sync;
   logic                eoc_s;

   logic [7:0]          mask_ext;
   logic [7:0]          mask_q_ext;
   logic                restart_due;
   logic                launch;
   ch_sel_t             first_sel;
   ch_sel_t             next_sel;

   adc_clk_div #(
      .HALF(HALF)
   ) u_clk_div (
      .clk     (clk),
      .rst     (rst),
      .adc_clk (adc_clk_int)
   );

   assign adc.adc_clk  = adc_clk_int;
   assign adc.adc_addr = addr_q;
   assign adc.adc_ale  = ale_q;
   assign adc.adc_st   = st_q;
   assign adc.adc_oe   = oe_q;

   // EOC comes straight from the converter, so it is brought into the clk domain first.
   always_ff @(posedge clk) begin
      if (rst) eoc_sync <= '0;
      else     eoc_sync <= {eoc_sync[0], adc.adc_eoc};
   end
   assign eoc_s = eoc_sync[1];

   // Channels at or above CH_NUM are zero here and can never be selected.
   assign mask_ext   = 8'(ch_mask);
   assign mask_q_ext = 8'(mask_q);

   always_comb begin
      // NOTE: conditionally written signals get a default first, otherwise a latch is inferred.
      restart_due = 1'b0;
      if ((state == FRAME_WAIT) && cont && (frame_cnt == FRAME_LAST))
         restart_due = 1'b1;
      launch    = ((state == IDLE) && start) || restart_due;
      first_sel = next_enabled_ch(mask_ext, -1);
      next_sel  = next_enabled_ch(mask_q_ext, int'(addr_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tmr         <= '0;
         frame_cnt   <= '0;
         mask_q      <= '0;
         cont_q      <= 1'b0;
         addr_q      <= '0;
         ale_q       <= 1'b0;
         st_q        <= 1'b0;
         oe_q        <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         smp_valid   <= 1'b0;
         smp_ch      <= '0;
         smp_data    <= '0;
         // NOTE: the result array is a handful of flops, so it is cleared by reset like any other register.
         ch_data     <= '0;
         err_timeout <= 1'b0;
         err_ch      <= '0;
      end else begin
         frame_done <= 1'b0;
         smp_valid  <= 1'b0;
         if (frame_cnt != FRAME_LAST)
            frame_cnt <= frame_cnt + 1'b1;

         if (launch) begin
            // Frame start, shared by a user start and a continuous-mode restart.
            mask_q      <= ch_mask;
            cont_q      <= cont;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
            tmr         <= '0;
            if (first_sel.found) begin
               addr_q <= first_sel.ch;
               busy   <= 1'b1;
               state  <= SETUP;
            end else begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         end else begin
            unique case (state)
               IDLE: ;

               SETUP: begin
                  ale_q <= 1'b1;
                  st_q  <= 1'b1;
                  tmr   <= '0;
                  state <= LATCH;
               end

               LATCH: begin
                  if (tmr == ST_LAST) begin
                     ale_q <= 1'b0;
                     st_q  <= 1'b0;
                     tmr   <= '0;
                     state <= WAIT_FALL;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               // A missed falling edge is tolerated: the rising-edge wait still bounds the conversion.
               WAIT_FALL: begin
                  if (!eoc_s || (tmr == FALL_LAST)) begin
                     tmr   <= '0;
                     state <= WAIT_RISE;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               WAIT_RISE: begin
                  if (eoc_s) begin
                     oe_q  <= 1'b1;
                     tmr   <= '0;
                     state <= READ;
                  end else if (tmr == CONV_LAST) begin
                     err_timeout <= 1'b1;
                     err_ch      <= addr_q;
                     state       <= NEXT;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               READ: begin
                  if (tmr == OE_LAST) begin
                     oe_q      <= 1'b0;
                     smp_valid <= 1'b1;
                     smp_ch    <= addr_q;
                     smp_data  <= adc.adc_db;
                     for (int i = 0; i < CH_NUM; i++) begin
                        if (addr_q == 3'(i))
                           ch_data[i] <= adc.adc_db;
                     end
                     state <= NEXT;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end

               NEXT: begin
                  if (next_sel.found) begin
                     addr_q <= next_sel.ch;
                     state  <= SETUP;
                  end else begin
                     frame_done <= 1'b1;
                     if (cont_q) begin
                        state <= FRAME_WAIT;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end
               end

               // An overrun leaves frame_cnt saturated at FRAME_LAST, so the restart fires at once.
               FRAME_WAIT: begin
                  if (!cont) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc08xx_scan.sv
// Directed bench for adc08xx_scan: table of single-shot frames plus hand-written
// sequences for mask 0, EOC timeout, continuous frame rate, cont drop and reset abort.
`timescale 1ns/1ps
module tb_adc08xx_scan;

   localparam int CLK_FRE     = 50;
   localparam int ADC_CLK_FRE = 640;
   localparam int FRAME_FRE   = 10000;
   localparam int CH_NUM      = 8;
   localparam int DATA_W      = 8;
   localparam int CONV_TO_US  = 20;
   localparam int FRAME_CYC   = 5000;   // 1e6 * 50 / 10000
   localparam int MODEL_HOLD  = 1200;   // longer than the 1000-cycle EOC timeout

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          start = 1'b0;
   logic                          cont = 1'b0;
   logic [CH_NUM-1:0]             ch_mask = '0;
   logic                          busy;
   logic                          frame_done;
   logic                          smp_valid;
   logic [2:0]                    smp_ch;
   logic [DATA_W-1:0]             smp_data;
   logic [CH_NUM-1:0][DATA_W-1:0] ch_data;
   logic                          err_timeout;
   logic [2:0]                    err_ch;

   adc08xx_scan_if #(.DATA_W(DATA_W)) adc_if ();

   adc08xx_scan #(
      .CLK_FRE     (CLK_FRE),
      .ADC_CLK_FRE (ADC_CLK_FRE),
      .FRAME_FRE   (FRAME_FRE),
      .CH_NUM      (CH_NUM),
      .DATA_W      (DATA_W),
      .CONV_TO_US  (CONV_TO_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cont        (cont),
      .ch_mask     (ch_mask),
      .busy        (busy),
      .frame_done  (frame_done),
      .smp_valid   (smp_valid),
      .smp_ch      (smp_ch),
      .smp_data    (smp_data),
      .ch_data     (ch_data),
      .err_timeout (err_timeout),
      .err_ch      (err_ch),
      .adc         (adc_if)
   );

   always #10 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- ADC model ----------------
   logic [3:0] hold_ch = 4'hF;
   logic [7:0] data_base = 8'h00;
   logic [2:0] model_ch;

   initial begin
      adc_if.adc_eoc = 1'b1;
      adc_if.adc_db  = '0;
      forever begin
         @(posedge adc_if.adc_st);
         model_ch = adc_if.adc_addr;
         repeat (3) @(negedge clk);
         adc_if.adc_eoc = 1'b0;
         repeat (({1'b0, model_ch} == hold_ch) ? MODEL_HOLD : 20) @(negedge clk);
         adc_if.adc_db  = data_base + 8'(model_ch);
         adc_if.adc_eoc = 1'b1;
      end
   end

   // ---------------- Monitors (sampled 1 ns after the active edge) ----------------
   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] data;
   } smp_t;

   smp_t smp_q[$];
   int   fd_time[$];
   int   fd_cnt = 0;
   int   cyc = 0;
   bit   addr_mon = 1'b0;
   bit   pin_mon = 1'b0;
   int   bad_addr = 0;
   int   pin_act = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (smp_valid) smp_q.push_back({smp_ch, smp_data});
      if (frame_done) begin
         fd_cnt++;
         fd_time.push_back(cyc);
      end
      if (addr_mon && !(adc_if.adc_addr inside {3'd2, 3'd5, 3'd7})) bad_addr++;
      if (pin_mon && (adc_if.adc_ale || adc_if.adc_st || adc_if.adc_oe || busy)) pin_act++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   // ---------------- Helpers ----------------
   typedef struct {
      logic [7:0]      mask;
      logic [7:0]      base;
      int              n;
      logic [7:0][2:0] chs;    // chs[0] is the first expected channel
      bit              poke;   // pulse start mid-frame; it must be ignored
      bit              chk_addr;
   } vec_t;

   task automatic launch(input logic [7:0] m, input logic c);
      @(negedge clk);
      ch_mask = m;
      cont    = c;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int budget, input string name);
      int n = 0;
      while (fd_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (fd_cnt < target) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: frame_done count %0d, wanted %0d within %0d cycles", name, fd_cnt, target, budget);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},        busy,             '0);
      check({tag, "_frame_done"},  frame_done,       '0);
      check({tag, "_smp_valid"},   smp_valid,        '0);
      check({tag, "_smp_ch"},      smp_ch,           '0);
      check({tag, "_smp_data"},    smp_data,         '0);
      check({tag, "_ch_data"},     ch_data,          '0);
      check({tag, "_err_timeout"}, err_timeout,      '0);
      check({tag, "_err_ch"},      err_ch,           '0);
      check({tag, "_adc_addr"},    adc_if.adc_addr,  '0);
      check({tag, "_adc_ale"},     adc_if.adc_ale,   '0);
      check({tag, "_adc_st"},      adc_if.adc_st,    '0);
      check({tag, "_adc_oe"},      adc_if.adc_oe,    '0);
      check({tag, "_adc_clk"},     adc_if.adc_clk,   '0);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int q0 = smp_q.size();
      int f0 = fd_cnt;
      data_base = v.base;
      bad_addr  = 0;
      addr_mon  = v.chk_addr;
      launch(v.mask, 1'b0);
      if (v.poke) begin
         repeat (50) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_fd(f0 + 1, 4000, name);
      repeat (20) @(negedge clk);
      addr_mon = 1'b0;
      check({name, "_busy_after"}, busy, 1'b0);
      check({name, "_frame_done_cnt"}, fd_cnt - f0, 1);
      check({name, "_n_samples"}, smp_q.size() - q0, v.n);
      for (int i = 0; i < v.n; i++) begin
         if (q0 + i < smp_q.size()) begin
            check($sformatf("%s_smp%0d_ch", name, i), smp_q[q0 + i].ch, v.chs[i]);
            check($sformatf("%s_smp%0d_data", name, i), smp_q[q0 + i].data, v.base + 8'(v.chs[i]));
         end
         check($sformatf("%s_ch_data%0d", name, v.chs[i]), ch_data[v.chs[i]], v.base + 8'(v.chs[i]));
      end
      if (v.chk_addr) check({name, "_addr_only_enabled"}, bad_addr, 0);
   endtask

   // ---------------- Test sequence ----------------
   vec_t vecs[4];

   initial begin
      int q0;
      int f0;
      int n;

      vecs[0] = '{mask: 8'hFF, base: 8'h10, n: 8,
                  chs: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, poke: 1'b1, chk_addr: 1'b0};
      vecs[1] = '{mask: 8'b1010_0100, base: 8'h20, n: 3,
                  chs: {15'd0, 3'd7, 3'd5, 3'd2}, poke: 1'b0, chk_addr: 1'b1};
      vecs[2] = '{mask: 8'h01, base: 8'h38, n: 1,
                  chs: {21'd0, 3'd0}, poke: 1'b0, chk_addr: 1'b0};
      vecs[3] = '{mask: 8'h81, base: 8'h30, n: 2,
                  chs: {18'd0, 3'd7, 3'd0}, poke: 1'b0, chk_addr: 1'b0};

      // Reset state
      repeat (5) @(negedge clk);
      check_all_zero("rst_hold");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_frame_done", frame_done, 1'b0);

      // Single-shot frames from the table
      for (int v = 0; v < 4; v++)
         run_vec(vecs[v], $sformatf("vec%0d", v));

      // Empty mask: frame_done next cycle, busy never set, pins untouched (addr stays at 7)
      f0 = fd_cnt;
      pin_act = 0;
      pin_mon = 1'b1;
      @(negedge clk);
      ch_mask = 8'h00;
      cont    = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      check("mask0_frame_done", frame_done, 1'b1);
      check("mask0_busy", busy, 1'b0);
      @(negedge clk);
      check("mask0_pulse_width", frame_done, 1'b0);
      repeat (10) @(negedge clk);
      pin_mon = 1'b0;
      check("mask0_pins_quiet", pin_act, 0);
      check("mask0_addr", adc_if.adc_addr, 3'd7);
      check("mask0_fd_cnt", fd_cnt - f0, 1);

      // EOC stuck low on channel 3
      data_base = 8'h40;
      hold_ch   = 4'd3;
      q0 = smp_q.size();
      f0 = fd_cnt;
      launch(8'h0F, 1'b0);
      wait_fd(f0 + 1, 4000, "timeout_frame");
      check("timeout_flag", err_timeout, 1'b1);
      check("timeout_err_ch", err_ch, 3'd3);
      check("timeout_n_samples", smp_q.size() - q0, 3);
      for (int i = 0; i < 3; i++) begin
         if (q0 + i < smp_q.size())
            check($sformatf("timeout_smp%0d_ch", i), smp_q[q0 + i].ch, 3'(i));
         check($sformatf("timeout_ch_data%0d", i), ch_data[i], 8'h40 + 8'(i));
      end
      check("timeout_ch_data3_kept", ch_data[3], 8'h13);
      n = 0;
      while (!adc_if.adc_eoc && n < 2000) begin
         @(negedge clk);
         n++;
      end
      hold_ch = 4'hF;

      // Continuous mode: five frames, frame_done spaced by exactly FRAME_CYC
      data_base = 8'h50;
      q0 = smp_q.size();
      f0 = fd_cnt;
      launch(8'h01, 1'b1);
      check("cont_err_cleared", err_timeout, 1'b0);
      check("cont_busy", busy, 1'b1);
      wait_fd(f0 + 5, 5 * FRAME_CYC + 2000, "cont_frames");
      cont = 1'b0;
      for (int k = 1; k < 5; k++) begin
         if (fd_time.size() > f0 + k)
            check($sformatf("cont_period%0d", k), fd_time[f0 + k] - fd_time[f0 + k - 1], FRAME_CYC);
      end
      check("cont_n_samples", smp_q.size() - q0, 5);
      repeat (5) @(negedge clk);
      check("cont_stop_busy", busy, 1'b0);

      // Drop cont mid-frame: that frame completes, then the controller idles
      data_base = 8'h60;
      q0 = smp_q.size();
      f0 = fd_cnt;
      launch(8'hFF, 1'b1);
      n = 0;
      while (smp_q.size() < q0 + 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      cont = 1'b0;
      wait_fd(f0 + 1, 4000, "drop_frame");
      repeat (FRAME_CYC + 200) @(negedge clk);
      check("drop_fd_cnt", fd_cnt - f0, 1);
      check("drop_n_samples", smp_q.size() - q0, 8);
      check("drop_busy", busy, 1'b0);

      // Reset while OE is asserted
      data_base = 8'h70;
      launch(8'hFF, 1'b0);
      n = 0;
      while (!adc_if.adc_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_read", adc_if.adc_oe, 1'b1);
      repeat (10) @(negedge clk);
      f0 = fd_cnt;
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("rst_read");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("rst_no_frame_done", fd_cnt - f0, 0);

      // Fresh scan after the abort; ch_data holds only the new values
      q0 = smp_q.size();
      f0 = fd_cnt;
      launch(8'h24, 1'b0);
      wait_fd(f0 + 1, 4000, "post_rst_frame");
      repeat (5) @(negedge clk);
      check("post_rst_n_samples", smp_q.size() - q0, 2);
      if (q0 + 1 < smp_q.size()) begin
         check("post_rst_smp0", smp_q[q0], {3'd2, 8'h72});
         check("post_rst_smp1", smp_q[q0 + 1], {3'd5, 8'h75});
      end
      check("post_rst_ch_data", ch_data, {8'h00, 8'h00, 8'h75, 8'h00, 8'h00, 8'h72, 8'h00, 8'h00});
      check("post_rst_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
